// File: rtl/rf_access_pkg.sv
// Shared defaults, x0 address and FSM encoding for the register-file access sequencer.
package rf_access_pkg;

   localparam int unsigned RF_XLEN = 32;
   localparam int unsigned RF_AW   = 5;

   localparam logic [4:0] X0_ADDR = 5'd0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } rf_state_e;

endpackage

// File: rtl/rf_access_ctrl.sv
// Register-file access sequencer: one read-then-optional-write transaction at a time.
// Build option RF_X0_GUARD_EN: skip writes to x0 and return zero for x0 reads.
module rf_access_ctrl
   import rf_access_pkg::*;
#(
   parameter int unsigned XLEN = RF_XLEN,
   parameter int unsigned AW   = RF_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [AW-1:0]   req_rs1,
   input  logic [AW-1:0]   req_rs2,
   input  logic [AW-1:0]   req_rd,
   input  logic            req_wen,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rs1_data,
   output logic [XLEN-1:0] rsp_rs2_data,
   output logic            rf_we,
   output logic            rf_re,
   output logic [AW-1:0]   rf_rw_addr,
   output logic [AW-1:0]   rf_rd1_addr,
   output logic [XLEN-1:0] rf_wdata,
   input  logic [XLEN-1:0] rf_rd1,
   input  logic [XLEN-1:0] rf_rd2
);

   rf_state_e       r_state;
   rf_state_e       w_state_nxt;
   logic [AW-1:0]   r_rd;
   logic            r_wen;
   logic [XLEN-1:0] r_wdata;
   logic            w_accept;
   logic            w_do_write;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state; rf_rw_addr/rf_rd1_addr hold the captured rs1/rs2 while in READ.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = req_valid && req_ready;
      w_do_write  = r_wen;
      w_rs1_data  = rf_rd1;
      w_rs2_data  = rf_rd2;
`ifdef RF_X0_GUARD_EN
      if (r_rd == AW'(X0_ADDR))        w_do_write = 1'b0;
      if (rf_rw_addr == AW'(X0_ADDR))  w_rs1_data = '0;
      if (rf_rd1_addr == AW'(X0_ADDR)) w_rs2_data = '0;
`endif
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = READ;
         READ:    w_state_nxt = w_do_write ? WRITE : RESP;
         WRITE:   w_state_nxt = RESP;
         RESP:    if (rsp_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Registered outputs and holding registers, all derived from the next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rf_re        <= 1'b0;
         rf_we        <= 1'b0;
         rf_rw_addr   <= '0;
         rf_rd1_addr  <= '0;
         rf_wdata     <= '0;
         rsp_rs1_data <= '0;
         rsp_rs2_data <= '0;
         r_rd         <= '0;
         r_wen        <= 1'b0;
         r_wdata      <= '0;
      end else begin
         req_ready <= (w_state_nxt == IDLE);
         rsp_valid <= (w_state_nxt == RESP);
         rf_re     <= (w_state_nxt == READ);
         rf_we     <= (w_state_nxt == WRITE);
         if (r_state == IDLE && w_accept) begin
            rf_rw_addr  <= req_rs1;
            rf_rd1_addr <= req_rs2;
            r_rd        <= req_rd;
            r_wen       <= req_wen;
            r_wdata     <= req_wdata;
         end
         if (r_state == READ) begin
            rsp_rs1_data <= w_rs1_data;
            rsp_rs2_data <= w_rs2_data;
            if (w_do_write) begin
               rf_rw_addr <= r_rd;
               rf_wdata   <= r_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl: transaction-level reference model plus directed cases.
// Honours RF_X0_GUARD_EN when the design is built with it.
module tb_rf_access_ctrl;

`ifdef RF_X0_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen;
   logic [4:0]  req_rs1, req_rs2, req_rd;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rs1_data, rsp_rs2_data;
   logic        rf_we, rf_re;
   logic [4:0]  rf_rw_addr, rf_rd1_addr;
   logic [31:0] rf_wdata, rf_rd1, rf_rd2;
   logic        mem_clr;

   int ncomp = 0;
   int nerr  = 0;

   always #5 clk = ~clk;

   rf_access_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
      .req_wen(req_wen), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
      .rf_we(rf_we), .rf_re(rf_re),
      .rf_rw_addr(rf_rw_addr), .rf_rd1_addr(rf_rd1_addr),
      .rf_wdata(rf_wdata), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2)
   );

   // Register file environment (no reset, no x0 hardwiring).
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
      end else if (rf_we) begin
         mem[rf_rw_addr] <= rf_wdata;
      end
   end
   assign rf_rd1 = mem[rf_rw_addr];
   assign rf_rd2 = mem[rf_rd1_addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncomp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transaction accepted at edge t_acc reads at t_acc+1,
   // optionally writes at t_acc+2, and responds until the handshake edge.
   int          cyc = 0;
   int          t_acc;
   bit          m_busy = 1'b0, m_resp = 1'b0, m_wr = 1'b0;
   logic [4:0]  m_rd;
   logic [31:0] m_wdata, m_d1, m_d2;
   logic [31:0] sh [32];
   logic [4:0]  e_rw = '0, e_rd1 = '0;
   logic [31:0] e_wd = '0, e_q1 = '0, e_q2 = '0;

   always @(posedge clk) begin
      cyc++;
      if (mem_clr) for (int i = 0; i < 32; i++) sh[i] = 32'd0;
      if (m_busy && m_wr && cyc == t_acc + 2) sh[m_rd] = m_wdata;
      if (rst) begin
         m_busy = 1'b0; m_resp = 1'b0; m_wr = 1'b0;
         e_rw = '0; e_rd1 = '0; e_wd = '0; e_q1 = '0; e_q2 = '0;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy  = 1'b1;
            t_acc   = cyc;
            m_rd    = req_rd;
            m_wdata = req_wdata;
            m_wr    = req_wen && !(GUARD && req_rd == 5'd0);
            m_d1    = (GUARD && req_rs1 == 5'd0) ? 32'd0 : sh[req_rs1];
            m_d2    = (GUARD && req_rs2 == 5'd0) ? 32'd0 : sh[req_rs2];
            e_rw    = req_rs1;
            e_rd1   = req_rs2;
         end
      end else if (m_resp) begin
         if (rsp_ready) begin
            m_busy = 1'b0;
            m_resp = 1'b0;
         end
      end else if (cyc == t_acc + 1) begin
         e_q1 = m_d1;
         e_q2 = m_d2;
         if (m_wr) begin
            e_rw = m_rd;
            e_wd = m_wdata;
         end else begin
            m_resp = 1'b1;
         end
      end else if (cyc == t_acc + 2) begin
         m_resp = 1'b1;
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      chk("we_re_exclusive", 32'(rf_we && rf_re), 32'd0);
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rf_re", 32'(rf_re), 32'(m_busy && cyc == t_acc));
      chk("rf_we", 32'(rf_we), 32'(m_busy && m_wr && cyc == t_acc + 1));
      chk("rf_rw_addr", 32'(rf_rw_addr), 32'(e_rw));
      chk("rf_rd1_addr", 32'(rf_rd1_addr), 32'(e_rd1));
      chk("rf_wdata", rf_wdata, e_wd);
      chk("rsp_rs1_data", rsp_rs1_data, e_q1);
      chk("rsp_rs2_data", rsp_rs2_data, e_q2);
   end

   task automatic noise();
      req_valid = 1'b1;
      req_rs1   = 5'($urandom);
      req_rs2   = 5'($urandom);
      req_rd    = 5'($urandom);
      req_wen   = 1'($urandom);
      req_wdata = $urandom;
   endtask

   // One full transaction, entered and left at a negedge with the DUT idle.
   task automatic txn(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic wen, input logic [31:0] wd, input int hold, input bit nz,
                      output logic [31:0] d1, output logic [31:0] d2,
                      output int lat, output int we_seen);
      int n = 0;
      req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wen = wen; req_wdata = wd;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) begin
         nerr++;
         $display("FAIL accept_timeout: req_ready stuck low at %0t", $time);
      end
      we_seen = 0;
      @(negedge clk);
      if (nz) noise(); else req_valid = 1'b0;
      lat = 0;
      while (!rsp_valid && lat < 50) begin
         if (rf_we) we_seen++;
         @(negedge clk);
         if (nz) noise();
         lat++;
      end
      if (!rsp_valid) begin
         nerr++;
         $display("FAIL rsp_timeout: rsp_valid never rose at %0t", $time);
      end
      for (int i = 0; i < hold; i++) begin
         if (rf_we) we_seen++;
         @(negedge clk);
         if (nz) noise();
      end
      d1 = rsp_rs1_data;
      d2 = rsp_rs2_data;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_rf_we"}, 32'(rf_we), 32'd0);
      chk({tag, "_rf_re"}, 32'(rf_re), 32'd0);
      chk({tag, "_rf_rw_addr"}, 32'(rf_rw_addr), 32'd0);
      chk({tag, "_rf_rd1_addr"}, 32'(rf_rd1_addr), 32'd0);
      chk({tag, "_rf_wdata"}, rf_wdata, 32'd0);
      chk({tag, "_rsp_rs1"}, rsp_rs1_data, 32'd0);
      chk({tag, "_rsp_rs2"}, rsp_rs2_data, 32'd0);
   endtask

   initial begin
      logic [31:0] d1, d2, s1, s2;
      int lat, we, n;
      rst = 1'b1; mem_clr = 1'b1;
      req_valid = 1'b0; rsp_ready = 1'b0;
      req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_wen = 1'b0; req_wdata = '0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0; mem_clr = 1'b0;
      @(negedge clk);

      // Initialise x1=1, x2=3, x5=2, x9=8 through the block itself.
      txn(5'd0, 5'd0, 5'd1, 1'b1, 32'd1, 0, 1'b0, d1, d2, lat, we);
      txn(5'd0, 5'd0, 5'd2, 1'b1, 32'd3, 0, 1'b0, d1, d2, lat, we);
      txn(5'd0, 5'd0, 5'd5, 1'b1, 32'd2, 0, 1'b0, d1, d2, lat, we);
      txn(5'd0, 5'd0, 5'd9, 1'b1, 32'd8, 0, 1'b0, d1, d2, lat, we);

      // Read-only request.
      txn(5'd1, 5'd2, 5'd7, 1'b0, 32'hFFFF_FFFF, 0, 1'b0, d1, d2, lat, we);
      chk("rd_only_rs1", d1, 32'd1);
      chk("rd_only_rs2", d2, 32'd3);
      chk("rd_only_latency", 32'(lat), 32'd1);
      chk("rd_only_we_pulses", 32'(we), 32'd0);

      // Read then write of the same register returns the old value.
      txn(5'd5, 5'd9, 5'd5, 1'b1, 32'hDEAD_BEEF, 2, 1'b1, d1, d2, lat, we);
      chk("rmw_rs1", d1, 32'd2);
      chk("rmw_rs2", d2, 32'd8);
      chk("rmw_latency", 32'(lat), 32'd2);
      chk("rmw_we_pulses", 32'(we), 32'd1);
      txn(5'd5, 5'd1, 5'd0, 1'b0, 32'd0, 0, 1'b0, d1, d2, lat, we);
      chk("rmw_readback", d1, 32'hDEAD_BEEF);

      // Back-pressure with a request held pending.
      req_rs1 = 5'd1; req_rs2 = 5'd9; req_wen = 1'b0; req_valid = 1'b1;
      @(negedge clk);
      req_rs1 = 5'd9; req_rs2 = 5'd1;
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      s1 = rsp_rs1_data; s2 = rsp_rs2_data;
      chk("bp_first_rs1", s1, 32'd1);
      chk("bp_first_rs2", s2, 32'd8);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("bp_req_ready", 32'(req_ready), 32'd0);
         chk("bp_rs1_stable", rsp_rs1_data, 32'd1);
         chk("bp_rs2_stable", rsp_rs2_data, 32'd8);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
      chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_next_accepted", 32'(req_ready), 32'd0);
      n = 0;
      while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
      chk("bp_second_rs1", rsp_rs1_data, 32'd8);
      chk("bp_second_rs2", rsp_rs2_data, 32'd1);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // Reset asserted during the WRITE cycle; the write still lands.
      req_rs1 = 5'd2; req_rs2 = 5'd2; req_rd = 5'd9; req_wen = 1'b1;
      req_wdata = 32'h0000_55AA; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rstw_in_read", 32'(rf_re), 32'd1);
      @(negedge clk);
      chk("rstw_in_write", 32'(rf_we), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("rstw");
      rst = 1'b0;
      txn(5'd9, 5'd1, 5'd0, 1'b0, 32'd0, 1, 1'b0, d1, d2, lat, we);
      chk("rstw_after_rs1", d1, 32'h0000_55AA);
      chk("rstw_after_rs2", d2, 32'd1);

      // x0 handling differs between the two builds.
      txn(5'd3, 5'd3, 5'd0, 1'b1, 32'd7, 0, 1'b0, d1, d2, lat, we);
      chk("x0_wr_latency", 32'(lat), GUARD ? 32'd1 : 32'd2);
      chk("x0_wr_we_pulses", 32'(we), GUARD ? 32'd0 : 32'd1);
      txn(5'd0, 5'd0, 5'd4, 1'b0, 32'd0, 0, 1'b0, d1, d2, lat, we);
      chk("x0_rd_rs1", d1, GUARD ? 32'd0 : 32'd7);
      chk("x0_rd_rs2", d2, GUARD ? 32'd0 : 32'd7);

      // Randomised traffic, checked by the every-cycle model compare.
      for (int k = 0; k < 300; k++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         txn(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), $urandom,
             $urandom_range(0, 3), 1'($urandom), d1, d2, lat, we);
      end

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete at %0t", $time);
      $fatal(1);
   end

endmodule
